slice_serial_adder: RTL and testbench

- Multi-cycle adder/subtractor for the AC/E datapath; computes A + B + Cin (or A - B) one SLICE-bit slice per clock, LSB slice first.
- Each slice's internal carries come from a look-ahead carry unit. The slice carry-out is registered and fed to the next slice's carry-in.
- Sits between the register file (operand source) and AC/E write-back (result consumer). Trades latency for a small carry network.

---
 rtl/slice_serial_adder_pkg.sv | 12 +
 rtl/slice_serial_adder_lac.sv | 27 ++
 rtl/slice_serial_adder.sv | 106 ++++++++++
 tb/tb_slice_serial_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_serial_adder_pkg.sv
// Shared types and constants for the slice-serial adder/subtractor.
package slice_serial_adder_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Width of the slice index; never below one bit so a single-slice build still has a counter.
    function automatic int idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction
endpackage

// File: rtl/slice_serial_adder_lac.sv
// Look-ahead carry unit for one slice: per-bit carries plus group propagate/generate.
module slice_serial_adder_lac #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] p,
    input  logic [BITS-1:0] g,
    input  logic            cin,
    output logic [BITS-1:0] carry,
    output logic            grp_p,
    output logic            grp_g
);
    // Carry into bit n expressed as a flat function of p/g/cin; synthesis collapses the loop.
    function automatic logic carry_into(input logic [BITS-1:0] pp, input logic [BITS-1:0] gg,
                                        input logic c0, input int n);
        logic t;
        t = c0;
        for (int j = 0; j < n; j++) t = gg[j] | (pp[j] & t);
        return t;
    endfunction

    always_comb begin
        carry = '0;
        for (int i = 0; i < BITS; i++) carry[i] = carry_into(p, g, cin, i);
        grp_g = carry_into(p, g, 1'b0, BITS);
        grp_p = &p;
    end
endmodule

// File: rtl/slice_serial_adder.sv
// Multi-cycle A+B+Cin / A-B: one SLICE-bit slice per clock, LSB slice first.
module slice_serial_adder
    import slice_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             v_out,
    output logic             busy_out,
    output logic             done_out
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = idx_w(NSLICE);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("slice_serial_adder: WIDTH must be a multiple of SLICE");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [KW-1:0]    k_q;
    logic             carry_q, c_q, v_q;

    logic [SLICE-1:0] a_sl, b_sl, p, g, carries, s_sum;
    logic             grp_p, grp_g, s_cout;

    assign a_sl   = a_q[k_q*SLICE +: SLICE];
    assign b_sl   = b_q[k_q*SLICE +: SLICE];
    assign p      = a_sl ^ b_sl;
    assign g      = a_sl & b_sl;
    assign s_sum  = p ^ carries;
    assign s_cout = grp_g | (grp_p & carry_q);

    slice_serial_adder_lac #(.BITS(SLICE)) u_lac (
        .p     (p),
        .g     (g),
        .cin   (carry_q),
        .carry (carries),
        .grp_p (grp_p),
        .grp_g (grp_g)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_in) begin
                    a_q     <= a_in;
                    b_q     <= sub_in ? ~b_in : b_in;
                    carry_q <= sub_in ? 1'b1 : c_in;
                    k_q     <= '0;
                    sum_q   <= '0;
                end
                RUN: begin
                    sum_q[k_q*SLICE +: SLICE] <= s_sum;
                    carry_q <= s_cout;
                    k_q     <= k_q + 1'b1;
                    // Overflow: carry into the top bit differs from carry out of it.
                    if (k_q == K_LAST) begin
                        c_q <= s_cout;
                        v_q <= carries[SLICE-1] ^ s_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_out  = sum_q;
    assign c_out    = c_q;
    assign v_out    = v_q;
    assign busy_out = (state_q == RUN);
    assign done_out = (state_q == DONE);
endmodule

// File: tb/tb_slice_serial_adder.sv
// Directed self-checking bench for slice_serial_adder (WIDTH=16, SLICE=4).
module tb_slice_serial_adder;
    logic        clk_in = 1'b0;
    logic        reset_n_in, start_in, sub_in, c_in;
    logic [15:0] a_in, b_in, sum_out;
    logic        c_out, v_out, busy_out, done_out;

    int total = 0;
    int bad   = 0;

    slice_serial_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .start_in   (start_in),
        .sub_in     (sub_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .c_in       (c_in),
        .sum_out    (sum_out),
        .c_out      (c_out),
        .v_out      (v_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one start pulse; returns after the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub);
        a_in = a; b_in = b; c_in = c; sub_in = sub; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        a_in = 16'hDEAD; b_in = 16'hBEEF; c_in = ~c; sub_in = ~sub;
    endtask

    // Count edges after acceptance until done_out is seen (bounded); 99 = timed out.
    task automatic wait_done(output int cycles);
        cycles = 99;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done_out === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0; start_in = 1'b1; sub_in = 1'b0; c_in = 1'b1;
        a_in = 16'h1234; b_in = 16'h4321;
        tick(); tick();
        total++;
        if ({sum_out, c_out, v_out, busy_out, done_out} !== 20'h0) begin
            bad++;
            $display("FAIL reset: sum=%h c=%b v=%b busy=%b done=%b, required all 0",
                     sum_out, c_out, v_out, busy_out, done_out);
        end
        start_in = 1'b0;
        reset_n_in = 1'b1;
        tick();
        total++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b done=%b, required 0 0", busy_out, done_out);
        end
    endtask

    task automatic test_add();
        int cyc;
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        total++;
        if (busy_out !== 1'b1 || sum_out !== 16'h0000) begin
            bad++;
            $display("FAIL add_start: busy=%b sum=%h, required busy=1 sum=0000", busy_out, sum_out);
        end
        wait_done(cyc);
        total++;
        if (cyc != 4) begin
            bad++;
            $display("FAIL add_latency: got %0d cycles, required 4", cyc);
        end
        total++;
        if (sum_out !== 16'h5555 || c_out !== 1'b0 || v_out !== 1'b0 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL add_result: sum=%h c=%b v=%b busy=%b, required 5555 0 0 0",
                     sum_out, c_out, v_out, busy_out);
        end
        tick();
        total++;
        if (done_out !== 1'b0 || sum_out !== 16'h5555) begin
            bad++;
            $display("FAIL add_pulse: done=%b sum=%h, required done=0 sum held 5555", done_out, sum_out);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        launch(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_done(cyc);
        total++;
        if (cyc != 4 || sum_out !== 16'h0000 || c_out !== 1'b1 || v_out !== 1'b0) begin
            bad++;
            $display("FAIL ripple_ffff: cyc=%0d sum=%h c=%b v=%b, required 4 0000 1 0",
                     cyc, sum_out, c_out, v_out);
        end
        tick();
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(cyc);
        total++;
        if (cyc != 4 || sum_out !== 16'h8000 || c_out !== 1'b0 || v_out !== 1'b1) begin
            bad++;
            $display("FAIL ripple_7fff: cyc=%0d sum=%h c=%b v=%b, required 4 8000 0 1",
                     cyc, sum_out, c_out, v_out);
        end
        tick();
    endtask

    task automatic test_subtract();
        int cyc;
        launch(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(cyc);
        total++;
        if (cyc != 4 || sum_out !== 16'hFFFE || c_out !== 1'b0 || v_out !== 1'b0) begin
            bad++;
            $display("FAIL sub_5_7: cyc=%0d sum=%h c=%b v=%b, required 4 fffe 0 0",
                     cyc, sum_out, c_out, v_out);
        end
        tick();
        launch(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done(cyc);
        total++;
        if (cyc != 4 || sum_out !== 16'h7FFF || c_out !== 1'b1 || v_out !== 1'b1) begin
            bad++;
            $display("FAIL sub_8000_1: cyc=%0d sum=%h c=%b v=%b, required 4 7fff 1 1",
                     cyc, sum_out, c_out, v_out);
        end
        tick();
    endtask

    task automatic test_busy_abort();
        int cyc;
        // Previous op left c_out=1, v_out=1; they must hold until the final slice.
        launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
        tick();
        a_in = 16'h1111; b_in = 16'h1111; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        total++;
        if (busy_out !== 1'b1 || c_out !== 1'b1 || v_out !== 1'b1) begin
            bad++;
            $display("FAIL busy_hold: busy=%b c=%b v=%b, required 1 1 1", busy_out, c_out, v_out);
        end
        wait_done(cyc);
        total++;
        if (cyc != 2 || sum_out !== 16'h0100 || c_out !== 1'b0 || v_out !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore: remaining=%0d sum=%h c=%b v=%b, required 2 0100 0 0",
                     cyc, sum_out, c_out, v_out);
        end
        tick();
        total++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            bad++;
            $display("FAIL no_requeue: busy=%b done=%b, required 0 0", busy_out, done_out);
        end

        // Abort with reset while slice k=2 is pending.
        launch(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick(); tick();
        reset_n_in = 1'b0;
        tick();
        reset_n_in = 1'b1;
        total++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || sum_out !== 16'h0000 ||
            c_out !== 1'b0 || v_out !== 1'b0) begin
            bad++;
            $display("FAIL abort: busy=%b done=%b sum=%h c=%b v=%b, required all 0",
                     busy_out, done_out, sum_out, c_out, v_out);
        end
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_out !== 1'b0) cyc++;
        end
        total++;
        if (cyc != 0) begin
            bad++;
            $display("FAIL abort_done: done seen %0d times, required 0", cyc);
        end

        launch(16'h0001, 16'h0002, 1'b0, 1'b0);
        wait_done(cyc);
        total++;
        if (cyc != 4 || sum_out !== 16'h0003 || c_out !== 1'b0 || v_out !== 1'b0) begin
            bad++;
            $display("FAIL after_abort: cyc=%0d sum=%h c=%b v=%b, required 4 0003 0 0",
                     cyc, sum_out, c_out, v_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        // start held high: second op accepted in the IDLE cycle after DONE.
        a_in = 16'h0F0F; b_in = 16'h0101; c_in = 1'b1; sub_in = 1'b0; start_in = 1'b1;
        cyc = 99;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done_out === 1'b1) begin
                cyc = i;
                break;
            end
        end
        total++;
        if (cyc != 5 || sum_out !== 16'h1011) begin
            bad++;
            $display("FAIL b2b_first: cyc=%0d sum=%h, required 5 1011", cyc, sum_out);
        end
        a_in = 16'h0002; b_in = 16'h0003; c_in = 1'b0;
        cyc = 99;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done_out === 1'b1) begin
                cyc = i;
                break;
            end
        end
        start_in = 1'b0;
        total++;
        if (cyc != 6 || sum_out !== 16'h0005) begin
            bad++;
            $display("FAIL b2b_second: cyc=%0d sum=%h, required 6 0005", cyc, sum_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ripple();
        test_subtract();
        test_busy_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
